// File: rtl/control_partida.sv
// Game-round supervisor: tracks lives, countdown and goals for one round and raises
// the win/lose flags that the main-menu FSM waits on. All outputs are registered.
module control_partida #(
  parameter int VIDAS_INI    = 3,
  parameter int TIEMPO_BASE  = 90,
  parameter int TIEMPO_PASO  = 15,
  parameter int METAS_GANAR  = 5,
  parameter int TICKS_INMUNE = 2
) (
  input  logic       CP_CLOCK_50,
  input  logic       CP_RESET,
  input  logic [2:0] CP_ESTADO_IN,
  input  logic [1:0] CP_NVL_IN,
  input  logic       CP_CN_IN,
  input  logic       CP_META,
  input  logic       CP_COLISION,
  input  logic       CP_TICK,
  output logic       CP_GANO,
  output logic       CP_PERDIO,
  output logic [1:0] CP_VIDAS,
  output logic [7:0] CP_TIEMPO,
  output logic [2:0] CP_METAS,
  output logic [2:0] CP_VEL_OUT,
  output logic       CP_ACTIVO
);

  typedef enum logic [2:0] {
    IDLE, ARMADO, JUGANDO, RESPAWN, GANO, PERDIO
  } estado_t;

  localparam logic [1:0] VIDAS_C  = 2'(VIDAS_INI);
  localparam logic [2:0] METAS_C  = 3'(METAS_GANAR);
  localparam logic [1:0] INMUNE_C = 2'(TICKS_INMUNE);

  estado_t    estado_q;
  logic [1:0] nvl_q;
  logic [1:0] vidas_q;
  logic [7:0] tiempo_q;
  logic [2:0] metas_q;
  logic [2:0] vel_q;
  logic [1:0] inmune_q;
  logic       gano_q;
  logic       perdio_q;
  logic       activo_q;

  int         carga_int;
  logic [7:0] carga;
  logic [7:0] tiempo_d;
  logic [2:0] metas_d;
  logic       juego;
  logic       timeout;
  logic       gana;
  logic       ultima_vida;

  // Round time shrinks with level; out-of-range results are clamped into 1..255.
  always_comb begin
    carga_int = TIEMPO_BASE - TIEMPO_PASO * int'(CP_NVL_IN);
    if (carga_int < 1)
      carga = 8'd1;
    else if (carga_int > 255)
      carga = 8'd255;
    else
      carga = 8'(carga_int);
  end

  assign juego       = (CP_ESTADO_IN == 3'b111);
  assign tiempo_d    = (CP_TICK && tiempo_q != 8'd0) ? tiempo_q - 8'd1 : tiempo_q;
  assign metas_d     = metas_q + 3'd1;
  assign timeout     = CP_TICK && (tiempo_q == 8'd1);
  assign gana        = CP_META && (metas_d == METAS_C);
  assign ultima_vida = (vidas_q <= 2'd1);

  always_ff @(posedge CP_CLOCK_50) begin
    if (CP_RESET) begin
      estado_q <= IDLE;
      nvl_q    <= '0;
      vidas_q  <= '0;
      tiempo_q <= '0;
      metas_q  <= '0;
      vel_q    <= '0;
      inmune_q <= '0;
      gano_q   <= 1'b0;
      perdio_q <= 1'b0;
      activo_q <= 1'b0;
    end else begin
      // Load strobe is honoured only before play starts.
      if (CP_CN_IN && (estado_q == IDLE || estado_q == ARMADO)) begin
        nvl_q    <= CP_NVL_IN;
        vidas_q  <= VIDAS_C;
        tiempo_q <= carga;
        metas_q  <= '0;
        vel_q    <= {1'b0, CP_NVL_IN} + 3'd1;
      end
      case (estado_q)
        IDLE: begin
          if (CP_CN_IN)
            estado_q <= ARMADO;
        end
        ARMADO: begin
          if (juego) begin
            estado_q <= JUGANDO;
            activo_q <= 1'b1;
          end
        end
        JUGANDO: begin
          if (!juego) begin
            estado_q <= IDLE;
            activo_q <= 1'b0;
          end else begin
            tiempo_q <= tiempo_d;
            if (CP_META)
              metas_q <= metas_d;
            else if (CP_COLISION && vidas_q != 2'd0)
              vidas_q <= vidas_q - 2'd1;
            // Win beats both a simultaneous timeout and a dropped collision.
            if (gana) begin
              estado_q <= GANO;
              gano_q   <= 1'b1;
              activo_q <= 1'b0;
            end else if (timeout || (!CP_META && CP_COLISION && ultima_vida)) begin
              estado_q <= PERDIO;
              perdio_q <= 1'b1;
              activo_q <= 1'b0;
            end else if (!CP_META && CP_COLISION) begin
              estado_q <= RESPAWN;
              inmune_q <= INMUNE_C;
            end
          end
        end
        RESPAWN: begin
          if (!juego) begin
            estado_q <= IDLE;
            activo_q <= 1'b0;
          end else if (CP_TICK) begin
            tiempo_q <= tiempo_d;
            if (inmune_q != 2'd0)
              inmune_q <= inmune_q - 2'd1;
            if (timeout) begin
              estado_q <= PERDIO;
              perdio_q <= 1'b1;
              activo_q <= 1'b0;
            end else if (inmune_q <= 2'd1) begin
              estado_q <= JUGANDO;
            end
          end
        end
        GANO, PERDIO: begin
          if (!juego) begin
            estado_q <= IDLE;
            gano_q   <= 1'b0;
            perdio_q <= 1'b0;
          end
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign CP_GANO    = gano_q;
  assign CP_PERDIO  = perdio_q;
  assign CP_VIDAS   = vidas_q;
  assign CP_TIEMPO  = tiempo_q;
  assign CP_METAS   = metas_q;
  assign CP_VEL_OUT = vel_q;
  assign CP_ACTIVO  = activo_q;

endmodule

// File: tb/tb_control_partida.sv
// Bench for control_partida: three instances differing only in TIEMPO_BASE (90, 3, 20);
// expected output snapshots are queued when stimulus is driven and popped after the edge.
module tb_control_partida;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic [2:0] est;
  logic [1:0] nvl;
  logic       cn, meta, col, tick;

  typedef struct packed {
    logic       gano;
    logic       perdio;
    logic [1:0] vidas;
    logic [7:0] tiempo;
    logic [2:0] metas;
    logic [2:0] vel;
    logic       activo;
  } obs_t;

  logic       gano   [3];
  logic       perdio [3];
  logic [1:0] vidas  [3];
  logic [7:0] tiempo [3];
  logic [2:0] metas  [3];
  logic [2:0] vel    [3];
  logic       activo [3];
  obs_t       obs    [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      control_partida #(
        .TIEMPO_BASE((gi == 0) ? 90 : (gi == 1) ? 3 : 20)
      ) u_dut (
        .CP_CLOCK_50 (clk),
        .CP_RESET    (rst),
        .CP_ESTADO_IN(est),
        .CP_NVL_IN   (nvl),
        .CP_CN_IN    (cn),
        .CP_META     (meta),
        .CP_COLISION (col),
        .CP_TICK     (tick),
        .CP_GANO     (gano[gi]),
        .CP_PERDIO   (perdio[gi]),
        .CP_VIDAS    (vidas[gi]),
        .CP_TIEMPO   (tiempo[gi]),
        .CP_METAS    (metas[gi]),
        .CP_VEL_OUT  (vel[gi]),
        .CP_ACTIVO   (activo[gi])
      );
      assign obs[gi] = {gano[gi], perdio[gi], vidas[gi], tiempo[gi], metas[gi], vel[gi], activo[gi]};
    end
  endgenerate

  int   checks = 0;
  int   passed = 0;
  obs_t exp_q[$];
  obs_t e;
  int   mt;

  function automatic obs_t mk(input int g, input int p, input int v, input int t,
                              input int m, input int vl, input int act);
    obs_t r;
    r.gano   = g[0];
    r.perdio = p[0];
    r.vidas  = 2'(v);
    r.tiempo = 8'(t);
    r.metas  = 3'(m);
    r.vel    = 3'(vl);
    r.activo = act[0];
    return r;
  endfunction

  task automatic step(input int e_est, input int e_cn, input int e_meta,
                      input int e_col, input int e_tick);
    est  = 3'(e_est);
    cn   = e_cn[0];
    meta = e_meta[0];
    col  = e_col[0];
    tick = e_tick[0];
    @(posedge clk);
    #1;
    cn   = 1'b0;
    meta = 1'b0;
    col  = 1'b0;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvl = 2'd0;
    exp_q.push_back(mk(0, 0, 3, 90, 0, 1, 0));
    step(0, 1, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL reset_load got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 3, 90, 0, 1, 1));
    step(7, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL reset_play got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 2, 90, 0, 1, 1));
    step(7, 0, 0, 1, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL reset_col got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 2, 40, 0, 1, 1));
    for (int i = 0; i < 50; i++) step(7, 0, 0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL reset_midround got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    step(7, 0, 0, 0, 0);
    rst = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL reset_clear got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    step(7, 0, 1, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL reset_meta_ignored got=%h exp=%h", obs[0], e); else passed++;
  endtask

  task automatic test_win();
    do_reset();
    nvl = 2'd2;
    exp_q.push_back(mk(0, 0, 3, 60, 0, 3, 0));
    step(0, 1, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL win_load got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 3, 60, 0, 3, 1));
    step(7, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL win_play got=%h exp=%h", obs[0], e); else passed++;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(int'(i == 4), 0, 3, 60, i + 1, 3, int'(i != 4)));
      step(7, 0, 1, 0, 0);
      e = exp_q.pop_front(); checks++;
      if (obs[0] !== e) $display("FAIL win_meta%0d got=%h exp=%h", i, obs[0], e); else passed++;
    end
    exp_q.push_back(mk(1, 0, 3, 60, 5, 3, 0));
    step(7, 0, 1, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL win_held got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 3, 60, 5, 3, 0));
    step(5, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL win_leave got=%h exp=%h", obs[0], e); else passed++;
  endtask

  task automatic test_lives();
    do_reset();
    nvl = 2'd0;
    step(0, 1, 0, 0, 0);
    step(7, 0, 0, 0, 0);
    mt = 90;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(0, int'(k == 2), 2 - k, mt, 0, 1, int'(k != 2)));
      step(7, 0, 0, 1, 0);
      e = exp_q.pop_front(); checks++;
      if (obs[0] !== e) $display("FAIL lives_col%0d got=%h exp=%h", k, obs[0], e); else passed++;
      if (k == 0) begin
        exp_q.push_back(mk(0, 0, 2, mt, 0, 1, 1));
        step(7, 0, 0, 1, 0);
        e = exp_q.pop_front(); checks++;
        if (obs[0] !== e) $display("FAIL lives_respawn_col got=%h exp=%h", obs[0], e); else passed++;
      end
      if (k < 2) begin
        for (int j = 0; j < 3; j++) step(7, 0, 0, 0, 1);
        mt = mt - 3;
      end
    end
    exp_q.push_back(mk(0, 1, 0, mt, 0, 1, 0));
    step(7, 0, 0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL lives_frozen got=%h exp=%h", obs[0], e); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    nvl = 2'd0;
    exp_q.push_back(mk(0, 0, 3, 3, 0, 1, 0));
    step(0, 1, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[1] !== e) $display("FAIL timeout_load got=%h exp=%h", obs[1], e); else passed++;
    step(7, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(0, int'(i == 2), 3, 2 - i, 0, 1, int'(i != 2)));
      step(7, 0, 0, 0, 1);
      e = exp_q.pop_front(); checks++;
      if (obs[1] !== e) $display("FAIL timeout_tick%0d got=%h exp=%h", i, obs[1], e); else passed++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    nvl = 2'd0;
    step(0, 1, 0, 0, 0);
    step(7, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(7, 0, 1, 0, 0);
    exp_q.push_back(mk(0, 0, 3, 1, 4, 1, 1));
    step(7, 0, 0, 0, 1);
    step(7, 0, 0, 0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs[1] !== e) $display("FAIL simul_setup got=%h exp=%h", obs[1], e); else passed++;
    exp_q.push_back(mk(1, 0, 3, 0, 5, 1, 0));
    step(7, 0, 1, 1, 1);
    e = exp_q.pop_front(); checks++;
    if (obs[1] !== e) $display("FAIL simul_win got=%h exp=%h", obs[1], e); else passed++;
  endtask

  task automatic test_clamp();
    do_reset();
    nvl = 2'd3;
    exp_q.push_back(mk(0, 0, 3, 1, 0, 4, 0));
    exp_q.push_back(mk(0, 0, 3, 45, 0, 4, 0));
    step(0, 1, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[2] !== e) $display("FAIL clamp_low got=%h exp=%h", obs[2], e); else passed++;
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL clamp_lvl3 got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 3, 1, 0, 4, 0));
    step(5, 0, 1, 1, 1);
    e = exp_q.pop_front(); checks++;
    if (obs[2] !== e) $display("FAIL clamp_armed_hold got=%h exp=%h", obs[2], e); else passed++;
    nvl = 2'd1;
    exp_q.push_back(mk(0, 0, 3, 5, 0, 2, 0));
    exp_q.push_back(mk(0, 0, 3, 75, 0, 2, 0));
    step(0, 1, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[2] !== e) $display("FAIL clamp_relatch got=%h exp=%h", obs[2], e); else passed++;
    e = exp_q.pop_front(); checks++;
    if (obs[0] !== e) $display("FAIL clamp_relatch_lvl1 got=%h exp=%h", obs[0], e); else passed++;
    exp_q.push_back(mk(0, 0, 3, 5, 0, 2, 1));
    step(7, 0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (obs[2] !== e) $display("FAIL clamp_play got=%h exp=%h", obs[2], e); else passed++;
  endtask

  initial begin
    rst  = 1'b1;
    est  = 3'd0;
    nvl  = 2'd0;
    cn   = 1'b0;
    meta = 1'b0;
    col  = 1'b0;
    tick = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs[0] !== obs_t'(0)) $display("FAIL reset_state got=%h exp=0", obs[0]); else passed++;
    test_reset();
    test_win();
    test_lives();
    test_timeout();
    test_simultaneous();
    test_clamp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
